// File: rtl/noc_pkg.sv
// Shared NoC router definitions: crossbar select codes, port indices,
// output-port controller state encoding and a grant-validity helper.
package noc_pkg;

    // Crossbar select codes for an output port
    localparam logic [2:0] CS_N    = 3'd0;
    localparam logic [2:0] CS_S    = 3'd1;
    localparam logic [2:0] CS_W    = 3'd2;
    localparam logic [2:0] CS_E    = 3'd3;
    localparam logic [2:0] CS_L    = 3'd4;
    localparam logic [2:0] CS_NONE = 3'd7;

    // Bit positions of each input inside the {n,s,w,e} vectors
    localparam int PORT_N = 3;
    localparam int PORT_S = 2;
    localparam int PORT_W = 1;
    localparam int PORT_E = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } port_ctrl_state_e;

    // True when exactly one bit of a 4-bit grant is set
    function automatic logic is_onehot4(input logic [3:0] v);
        logic [2:0] ones;
        ones = 3'd0;
        for (int i = 0; i < 4; i++) begin
            ones = ones + {2'b00, v[i]};
        end
        return (ones == 3'd1);
    endfunction

endpackage

// File: rtl/l_output_port_ctrl_chk.sv
// Protocol checker for the L output-port controller inputs.
module l_output_port_ctrl_chk (
    input logic       clk,
    input logic       reset,
    input logic [3:0] rrp_l_grant_i
);

    // The arbiter must never issue more than one grant at a time
    grant_onehot0_a : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(rrp_l_grant_i))
        else $error("l_output_port_ctrl_chk: non-one-hot grant %b", rrp_l_grant_i);

endmodule

// File: rtl/noc_credit_counter.sv
// Downstream buffer credit counter: starts full, decrements on a flit send,
// increments on a credit return, and latches a sticky error on overflow.
module noc_credit_counter #(
    parameter int BUF_DEPTH = 4,
    localparam int CW = $clog2(BUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          err
);

    localparam logic [CW-1:0] CNT_MAX  = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic [CW-1:0] count_r;
    logic          nonzero_r;
    logic          err_r;

    // Credit count, its nonzero flag and the sticky overflow error
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r   <= CNT_MAX;
            nonzero_r <= 1'b1;
            err_r     <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    if (count_r == CNT_MAX) begin
                        err_r <= 1'b1;
                    end else begin
                        count_r   <= count_r + CNT_ONE;
                        nonzero_r <= 1'b1;
                    end
                end
                2'b01: begin
                    if (count_r != CNT_ZERO) begin
                        count_r   <= count_r - CNT_ONE;
                        nonzero_r <= (count_r != CNT_ONE);
                    end else begin
                        count_r <= count_r;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign count   = count_r;
    assign nonzero = nonzero_r;
    assign err     = err_r;

endmodule

// File: rtl/l_output_port_ctrl.sv
// Wormhole output-port controller for the local (L) port. Locks the crossbar
// path from head to tail, pops the granted input buffer and gates every
// transfer on downstream credit availability.
module l_output_port_ctrl
    import noc_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    localparam int CW = $clog2(BUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    rrp_l_grant_i,
    input  logic [2:0]    rrp_l_priority_to_cs_i,
    input  logic [3:0]    in_flit_valid_i,
    input  logic [3:0]    in_flit_tail_i,
    input  logic          l_credit_return_i,
    output logic [2:0]    cs_l_sel_o,
    output logic [3:0]    l_flit_pop_o,
    output logic          l_out_valid_o,
    output logic          rr_downstream_credit_o,
    output logic          rr_change_order_o,
    output logic [CW-1:0] credit_count_o,
    output logic          credit_err_o
);

    port_ctrl_state_e state_r;
    logic [3:0]       lock_grant_r;
    logic [2:0]       lock_sel_r;

    logic [3:0]       active_grant_s;
    logic             send_s;
    logic             tail_s;
    logic [2:0]       sel_s;
    logic             credit_ok_s;

    noc_credit_counter #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_credit (
        .clk     (clk),
        .reset   (reset),
        .inc     (l_credit_return_i),
        .dec     (send_s),
        .count   (credit_count_o),
        .nonzero (credit_ok_s),
        .err     (credit_err_o)
    );

    // Select the active grant and decide whether a flit moves this cycle
    always_comb begin
        active_grant_s = 4'b0000;
        if (state_r == LOCKED) begin
            active_grant_s = lock_grant_r;
        end else if (is_onehot4(rrp_l_grant_i)) begin
            active_grant_s = rrp_l_grant_i;
        end else begin
            active_grant_s = 4'b0000;
        end
        send_s = (|(active_grant_s & in_flit_valid_i)) && credit_ok_s;
        tail_s = |(active_grant_s & in_flit_tail_i);
        sel_s  = CS_NONE;
        if (state_r == LOCKED) begin
            sel_s = lock_sel_r;
        end else if (send_s) begin
            sel_s = rrp_l_priority_to_cs_i;
        end else begin
            sel_s = CS_NONE;
        end
    end

    // Packet lock FSM: hold the path from a non-tail head until its tail leaves
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            lock_grant_r <= 4'b0000;
            lock_sel_r   <= CS_NONE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (send_s && !tail_s) begin
                        state_r      <= LOCKED;
                        lock_grant_r <= active_grant_s;
                        lock_sel_r   <= rrp_l_priority_to_cs_i;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOCKED: begin
                    if (send_s && tail_s) begin
                        state_r      <= IDLE;
                        lock_grant_r <= 4'b0000;
                        lock_sel_r   <= CS_NONE;
                    end else begin
                        state_r <= LOCKED;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    lock_grant_r <= 4'b0000;
                    lock_sel_r   <= CS_NONE;
                end
            endcase
        end
    end

    // Transfer-side outputs act in the same cycle as the flit moves
    assign cs_l_sel_o             = sel_s;
    assign l_flit_pop_o           = active_grant_s & {4{send_s}};
    assign l_out_valid_o          = send_s;
    assign rr_change_order_o      = send_s & tail_s;
    assign rr_downstream_credit_o = credit_ok_s;

endmodule

// File: tb/tb_l_output_port_ctrl.sv
// Self-checking bench for l_output_port_ctrl: reset check, a vector table,
// hand-written multi-cycle corner cases and a randomized run against a
// packet-level reference model.
module tb_l_output_port_ctrl;
    import noc_pkg::*;

    localparam int BUF_DEPTH = 4;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    grant = 4'b0000;
    logic [2:0]    prio = CS_NONE;
    logic [3:0]    valid = 4'b0000;
    logic [3:0]    tail = 4'b0000;
    logic          ret = 1'b0;
    logic [2:0]    cs_sel;
    logic [3:0]    pop;
    logic          out_valid;
    logic          credit_out;
    logic          change_order;
    logic [CW-1:0] credit_count;
    logic          credit_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (packet level)
    int         m_credits;
    bit         m_err;
    bit         m_locked;
    int         m_port;
    logic [2:0] m_sel;

    always #5 clk = ~clk;

    l_output_port_ctrl #(.BUF_DEPTH(BUF_DEPTH)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .rrp_l_grant_i          (grant),
        .rrp_l_priority_to_cs_i (prio),
        .in_flit_valid_i        (valid),
        .in_flit_tail_i         (tail),
        .l_credit_return_i      (ret),
        .cs_l_sel_o             (cs_sel),
        .l_flit_pop_o           (pop),
        .l_out_valid_o          (out_valid),
        .rr_downstream_credit_o (credit_out),
        .rr_change_order_o      (change_order),
        .credit_count_o         (credit_count),
        .credit_err_o           (credit_err)
    );

    l_output_port_ctrl_chk u_chk (
        .clk           (clk),
        .reset         (reset),
        .rrp_l_grant_i (grant)
    );

    typedef struct {
        logic [3:0] g;
        logic [2:0] p;
        logic [3:0] v;
        logic [3:0] t;
        logic       r;
        logic [3:0] e_pop;
        logic       e_valid;
        logic       e_change;
        logic [2:0] e_sel;
        logic [2:0] e_count;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int grant_port(input logic [3:0] g);
        case (g)
            4'b1000: return PORT_N;
            4'b0100: return PORT_S;
            4'b0010: return PORT_W;
            4'b0001: return PORT_E;
            default: return -1;
        endcase
    endfunction

    function automatic void model_reset();
        m_credits = BUF_DEPTH;
        m_err     = 1'b0;
        m_locked  = 1'b0;
        m_port    = -1;
        m_sel     = CS_NONE;
    endfunction

    // Which input the model would serve now, or -1
    function automatic int model_port();
        if (m_locked) return m_port;
        return grant_port(grant);
    endfunction

    function automatic bit model_send();
        int pt;
        pt = model_port();
        if (pt < 0) return 1'b0;
        return valid[pt] && (m_credits > 0);
    endfunction

    // Compare every output with the model before the clock edge
    task automatic model_check(input string tag);
        int         pt;
        bit         s;
        logic [3:0] e_pop;
        logic [2:0] e_sel;
        pt    = model_port();
        s     = model_send();
        e_pop = 4'b0000;
        if (s) e_pop[pt] = 1'b1;
        e_sel = m_locked ? m_sel : (s ? prio : CS_NONE);
        chk({tag, "_pop"},    {4'd0, pop},             {4'd0, e_pop});
        chk({tag, "_valid"},  {7'd0, out_valid},       {7'd0, s});
        chk({tag, "_change"}, {7'd0, change_order},    {7'd0, s && tail[pt]});
        chk({tag, "_sel"},    {5'd0, cs_sel},          {5'd0, e_sel});
        chk({tag, "_count"},  {5'd0, credit_count},    8'(m_credits));
        chk({tag, "_credit"}, {7'd0, credit_out},      {7'd0, m_credits != 0});
        chk({tag, "_err"},    {7'd0, credit_err},      {7'd0, m_err});
    endtask

    // Advance the model by one clock using the current inputs
    function automatic void model_step();
        int pt;
        bit s;
        pt = model_port();
        s  = model_send();
        if (s && !ret) m_credits--;
        else if (ret && !s) begin
            if (m_credits == BUF_DEPTH) m_err = 1'b1;
            else m_credits++;
        end
        if (s) begin
            if (tail[pt]) begin
                m_locked = 1'b0;
                m_sel    = CS_NONE;
            end else if (!m_locked) begin
                m_locked = 1'b1;
                m_port   = pt;
                m_sel    = prio;
            end
        end
    endfunction

    task automatic drive(input logic [3:0] g, input logic [2:0] p, input logic [3:0] v,
                         input logic [3:0] t, input logic r);
        grant = g; prio = p; valid = v; tail = t; ret = r;
    endtask

    // Drive one cycle, check against the model, then clock it
    task automatic run_cycle(input string tag, input logic [3:0] g, input logic [2:0] p,
                             input logic [3:0] v, input logic [3:0] t, input logic r);
        drive(g, p, v, t, r);
        #1;
        model_check(tag);
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic do_reset();
        drive(4'b0000, CS_NONE, 4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        // Single N flit, 3-flit S packet with W grant appearing mid-packet, then refill
        vecs[0] = '{4'b1000, CS_N, 4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1, CS_N,    3'd4};
        vecs[1] = '{4'b0100, CS_S, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0, CS_S,    3'd3};
        vecs[2] = '{4'b0010, CS_W, 4'b0110, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0, CS_S,    3'd2};
        vecs[3] = '{4'b0010, CS_W, 4'b0110, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, CS_S,    3'd1};
        vecs[4] = '{4'b0000, CS_NONE, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, CS_NONE, 3'd0};
        vecs[5] = '{4'b0000, CS_NONE, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, CS_NONE, 3'd0};
        vecs[6] = '{4'b0000, CS_NONE, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, CS_NONE, 3'd1};
        vecs[7] = '{4'b0000, CS_NONE, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, CS_NONE, 3'd2};
        vecs[8] = '{4'b0000, CS_NONE, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, CS_NONE, 3'd3};

        // Reset state
        @(posedge clk);
        #1;
        do_reset();
        #1;
        chk("rst_count",  {5'd0, credit_count}, 8'd4);
        chk("rst_credit", {7'd0, credit_out},   8'd1);
        chk("rst_sel",    {5'd0, cs_sel},       {5'd0, CS_NONE});
        chk("rst_pop",    {4'd0, pop},          8'd0);
        chk("rst_change", {7'd0, change_order}, 8'd0);
        chk("rst_err",    {7'd0, credit_err},   8'd0);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].g, vecs[i].p, vecs[i].v, vecs[i].t, vecs[i].r);
            #1;
            chk($sformatf("vec%0d_pop", i),    {4'd0, pop},          {4'd0, vecs[i].e_pop});
            chk($sformatf("vec%0d_valid", i),  {7'd0, out_valid},    {7'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d_change", i), {7'd0, change_order}, {7'd0, vecs[i].e_change});
            chk($sformatf("vec%0d_sel", i),    {5'd0, cs_sel},       {5'd0, vecs[i].e_sel});
            chk($sformatf("vec%0d_count", i),  {5'd0, credit_count}, {5'd0, vecs[i].e_count});
            @(posedge clk);
            #1;
            model_step();
        end
        chk("refill_count", {5'd0, credit_count}, 8'd4);

        // Credit exhaustion in the middle of a 5-flit W packet
        for (int i = 0; i < 4; i++) begin
            run_cycle("t4_body", 4'b0010, CS_W, 4'b0010, 4'b0000, 1'b0);
        end
        chk("t4_stall_count",  {5'd0, credit_count}, 8'd0);
        chk("t4_stall_credit", {7'd0, credit_out},   8'd0);
        run_cycle("t4_stall", 4'b1000, CS_N, 4'b1010, 4'b0010, 1'b0);
        run_cycle("t4_ret",   4'b1000, CS_N, 4'b1010, 4'b0010, 1'b1);
        drive(4'b1000, CS_N, 4'b1010, 4'b0010, 1'b0);
        #1;
        chk("t4_tail_pop",    {4'd0, pop},          8'b0000_0010);
        chk("t4_tail_change", {7'd0, change_order}, 8'd1);
        chk("t4_tail_sel",    {5'd0, cs_sel},       {5'd0, CS_W});
        run_cycle("t4_tail", 4'b1000, CS_N, 4'b1010, 4'b0010, 1'b0);
        run_cycle("t4_idle", 4'b0000, CS_NONE, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_cycle("t4_refill", 4'b0000, CS_NONE, 4'b0000, 4'b0000, 1'b1);
        end

        // Simultaneous send and return, then overflow return
        run_cycle("t5_a", 4'b0001, CS_E, 4'b0001, 4'b0001, 1'b0);
        run_cycle("t5_b", 4'b0001, CS_E, 4'b0001, 4'b0001, 1'b0);
        chk("t5_pre_count", {5'd0, credit_count}, 8'd2);
        run_cycle("t5_both", 4'b0001, CS_E, 4'b0001, 4'b0001, 1'b1);
        chk("t5_both_count", {5'd0, credit_count}, 8'd2);
        run_cycle("t5_r1", 4'b0000, CS_NONE, 4'b0000, 4'b0000, 1'b1);
        run_cycle("t5_r2", 4'b0000, CS_NONE, 4'b0000, 4'b0000, 1'b1);
        run_cycle("t5_over", 4'b0000, CS_NONE, 4'b0000, 4'b0000, 1'b1);
        chk("t5_over_count", {5'd0, credit_count}, 8'd4);
        chk("t5_over_err",   {7'd0, credit_err},   8'd1);
        run_cycle("t5_sticky", 4'b0000, CS_NONE, 4'b0000, 4'b0000, 1'b0);

        // Reset while a packet holds the lock
        run_cycle("t6_head", 4'b0100, CS_S, 4'b0100, 4'b0000, 1'b0);
        run_cycle("t6_body", 4'b0100, CS_S, 4'b0100, 4'b0000, 1'b0);
        do_reset();
        drive(4'b0000, CS_NONE, 4'b0100, 4'b0100, 1'b0);
        #1;
        chk("t6_sel",    {5'd0, cs_sel},       {5'd0, CS_NONE});
        chk("t6_count",  {5'd0, credit_count}, 8'd4);
        chk("t6_change", {7'd0, change_order}, 8'd0);
        chk("t6_pop",    {4'd0, pop},          8'd0);
        chk("t6_err",    {7'd0, credit_err},   8'd0);
        @(posedge clk);
        #1;
        model_step();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [3:0] rg;
            rg = 4'b0000;
            if ($urandom_range(0, 4) != 0) rg[$urandom_range(0, 3)] = 1'b1;
            run_cycle("rnd", rg, 3'($urandom_range(0, 4)), 4'($urandom),
                      4'($urandom), ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
